ibex_pmp_pipe: RTL and testbench

Next-generation PMP checker. It extends the existing combinational checker with a width-parametrised address path and the full OFF/TOR/NA4/NAPOT mode set. It also adds strict lowest-index region priority, a registered valid/ready response stage per channel, per-channel first-fault capture and saturating fault counters. It sits between the core's fetch/LSU request channels and the bus, and is fed by the CSR file's PMP config and address registers.

---
 rtl/ibex_pkg.sv | 50 +++++
 rtl/ibex_pmp_match.sv | 85 ++++++++
 rtl/ibex_pmp_pipe.sv | 121 ++++++++++++
 tb/tb_ibex_pmp_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared PMP types: privilege levels, access kinds, region config and fault record.
// Also holds the permission-select helper used by the region matcher.
package ibex_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    // Fault record is sized for the widest supported address; users keep the low bits.
    localparam int unsigned PMP_MAX_AW = 64;

    typedef struct packed {
        logic [PMP_MAX_AW-1:0] addr;
        pmp_req_e              req_type;
    } pmp_fault_t;

    function automatic logic pmp_perm(input pmp_cfg_t cfg, input pmp_req_e req_type);
        case (req_type)
            PMP_ACC_EXEC:  pmp_perm = cfg.exec;
            PMP_ACC_WRITE: pmp_perm = cfg.write;
            PMP_ACC_READ:  pmp_perm = cfg.read;
            default:       pmp_perm = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ibex_pmp_match.sv
// Combinational PMP lookup for one request: per-region match, lowest-index priority,
// and the M-mode / U-S-mode fault decision.
module ibex_pmp_match import ibex_pkg::*; #(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 16,
    parameter int unsigned PMPAddrWidth   = 34,
    localparam int unsigned RegionW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1
) (
    input  pmp_cfg_t                csr_pmp_cfg_i  [PMPNumRegions],
    input  logic [PMPAddrWidth-1:0] csr_pmp_addr_i [PMPNumRegions],
    input  logic [PMPAddrWidth-1:0] req_addr_i,
    input  pmp_req_e                req_type_i,
    input  priv_lvl_e               req_priv_i,
    output logic                    hit_o,
    output logic [RegionW-1:0]      region_o,
    output logic                    err_o
);
    localparam int unsigned Lsb  = PMPGranularity + 2;
    localparam int unsigned CmpW = PMPAddrWidth - Lsb;

    // Bit i is masked when every region-address bit below it is one; bit 0 always is.
    function automatic logic [CmpW-1:0] napot_mask(input logic [CmpW-1:0] a);
        logic run;
        run = 1'b1;
        for (int i = 0; i < CmpW; i++) begin
            napot_mask[i] = run;
            run           = run & a[i];
        end
    endfunction

    logic [CmpW-1:0]          a_cmp;
    logic [CmpW-1:0]          r_cmp;
    logic [CmpW-1:0]          prev_cmp;
    logic [PMPNumRegions-1:0] match;
    logic                     perm;
    logic                     lock;
    logic                     unused_low;

    assign a_cmp = req_addr_i[PMPAddrWidth-1:Lsb];

    always_comb begin
        prev_cmp = '0;
        r_cmp    = '0;
        match    = '0;
        for (int r = 0; r < PMPNumRegions; r++) begin
            r_cmp = csr_pmp_addr_i[r][PMPAddrWidth-1:Lsb];
            case (csr_pmp_cfg_i[r].mode)
                PMP_MODE_TOR:   match[r] = (a_cmp >= prev_cmp) && (a_cmp < r_cmp);
                PMP_MODE_NA4:   match[r] = (PMPGranularity == 0) && (a_cmp == r_cmp);
                PMP_MODE_NAPOT: match[r] = ((a_cmp ^ r_cmp) & ~napot_mask(r_cmp)) == '0;
                default:        match[r] = 1'b0;
            endcase
            prev_cmp = r_cmp;
        end
    end

    always_comb begin
        hit_o    = 1'b0;
        region_o = '0;
        perm     = 1'b0;
        lock     = 1'b0;
        // Walk downwards so the lowest matching index is the last to write.
        for (int r = PMPNumRegions - 1; r >= 0; r--) begin
            if (match[r]) begin
                hit_o    = 1'b1;
                region_o = RegionW'(r);
                perm     = pmp_perm(csr_pmp_cfg_i[r], req_type_i);
                lock     = csr_pmp_cfg_i[r].lock;
            end
        end
        if (req_priv_i == PRIV_LVL_M) begin
            err_o = hit_o & lock & ~perm;
        end else begin
            err_o = ~hit_o | ~perm;
        end
    end

    always_comb begin
        unused_low = ^req_addr_i[Lsb-1:0];
        for (int r = 0; r < PMPNumRegions; r++) begin
            unused_low = unused_low ^ (^csr_pmp_addr_i[r][Lsb-1:0]);
        end
    end

endmodule

// File: rtl/ibex_pmp_pipe.sv
// Multi-channel PMP checker with a one-cycle valid/ready response stage per channel,
// first-fault capture and a saturating fault counter per channel.
module ibex_pmp_pipe import ibex_pkg::*; #(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumChan     = 2,
    parameter int unsigned PMPNumRegions  = 16,
    parameter int unsigned PMPAddrWidth   = 34,
    parameter int unsigned FaultCntWidth  = 16,
    localparam int unsigned RegionW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  pmp_cfg_t                 csr_pmp_cfg_i  [PMPNumRegions],
    input  logic [PMPAddrWidth-1:0]  csr_pmp_addr_i [PMPNumRegions],
    input  logic [PMPNumChan-1:0]    req_valid_i,
    output logic [PMPNumChan-1:0]    req_ready_o,
    input  logic [PMPAddrWidth-1:0]  req_addr_i [PMPNumChan],
    input  pmp_req_e                 req_type_i [PMPNumChan],
    input  priv_lvl_e                req_priv_i [PMPNumChan],
    output logic [PMPNumChan-1:0]    rsp_valid_o,
    input  logic [PMPNumChan-1:0]    rsp_ready_i,
    output logic [PMPNumChan-1:0]    rsp_err_o,
    output logic [PMPNumChan-1:0]    rsp_hit_o,
    output logic [RegionW-1:0]       rsp_region_o [PMPNumChan],
    input  logic [PMPNumChan-1:0]    fault_clear_i,
    output logic [PMPNumChan-1:0]    fault_valid_o,
    output logic [PMPAddrWidth-1:0]  fault_addr_o [PMPNumChan],
    output pmp_req_e                 fault_type_o [PMPNumChan],
    output logic [FaultCntWidth-1:0] fault_cnt_o  [PMPNumChan]
);

    for (genvar c = 0; c < PMPNumChan; c++) begin : g_chan
        logic                     m_hit, m_err;
        logic [RegionW-1:0]       m_region;
        logic                     vld_q, err_q, hit_q;
        logic [RegionW-1:0]       region_q;
        logic [PMPAddrWidth-1:0]  addr_q;
        pmp_req_e                 type_q;
        logic                     fault_vld_q, fault_vld_d;
        pmp_fault_t               fault_q, fault_d;
        logic [FaultCntWidth-1:0] cnt_q, cnt_d;
        logic                     accept, fault_hs;
        logic                     unused_fault_hi;

        ibex_pmp_match #(
            .PMPGranularity (PMPGranularity),
            .PMPNumRegions  (PMPNumRegions),
            .PMPAddrWidth   (PMPAddrWidth)
        ) u_match (
            .csr_pmp_cfg_i  (csr_pmp_cfg_i),
            .csr_pmp_addr_i (csr_pmp_addr_i),
            .req_addr_i     (req_addr_i[c]),
            .req_type_i     (req_type_i[c]),
            .req_priv_i     (req_priv_i[c]),
            .hit_o          (m_hit),
            .region_o       (m_region),
            .err_o          (m_err)
        );

        assign req_ready_o[c] = ~vld_q | rsp_ready_i[c];
        assign accept         = req_valid_i[c] & req_ready_o[c];
        assign fault_hs       = vld_q & rsp_ready_i[c] & err_q;

        always_comb begin
            fault_vld_d = fault_vld_q;
            fault_d     = fault_q;
            cnt_d       = cnt_q;
            // A clear in the same cycle as a faulting handshake yields the new record.
            if (fault_hs && (!fault_vld_q || fault_clear_i[c])) begin
                fault_vld_d                        = 1'b1;
                fault_d.addr                       = '0;
                fault_d.addr[PMPAddrWidth-1:0]     = addr_q;
                fault_d.req_type                   = type_q;
            end else if (fault_clear_i[c]) begin
                fault_vld_d = 1'b0;
            end
            if (fault_hs && (cnt_q != '1)) begin
                cnt_d = cnt_q + FaultCntWidth'(1);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q       <= 1'b0;
                err_q       <= 1'b0;
                hit_q       <= 1'b0;
                region_q    <= '0;
                addr_q      <= '0;
                type_q      <= PMP_ACC_EXEC;
                fault_vld_q <= 1'b0;
                fault_q     <= '{addr: '0, req_type: PMP_ACC_EXEC};
                cnt_q       <= '0;
            end else begin
                if (accept) begin
                    vld_q    <= 1'b1;
                    err_q    <= m_err;
                    hit_q    <= m_hit;
                    region_q <= m_region;
                    addr_q   <= req_addr_i[c];
                    type_q   <= req_type_i[c];
                end else if (rsp_ready_i[c]) begin
                    vld_q <= 1'b0;
                end
                fault_vld_q <= fault_vld_d;
                fault_q     <= fault_d;
                cnt_q       <= cnt_d;
            end
        end

        assign rsp_valid_o[c]   = vld_q;
        assign rsp_err_o[c]     = err_q;
        assign rsp_hit_o[c]     = hit_q;
        assign rsp_region_o[c]  = region_q;
        assign fault_valid_o[c] = fault_vld_q;
        assign fault_addr_o[c]  = fault_q.addr[PMPAddrWidth-1:0];
        assign fault_type_o[c]  = fault_q.req_type;
        assign fault_cnt_o[c]   = cnt_q;
        assign unused_fault_hi  = ^fault_q.addr[PMP_MAX_AW-1:PMPAddrWidth];
    end

endmodule

// File: tb/tb_ibex_pmp_pipe.sv
// Directed bench for ibex_pmp_pipe with a response scoreboard on channel 0.
module tb_ibex_pmp_pipe;
    import ibex_pkg::*;

    localparam int NREG = 4;
    localparam int NCH  = 2;
    localparam int AW   = 34;
    localparam int CW   = 2;
    localparam int RW   = 2;

    logic clk = 1'b0;
    logic rst;

    pmp_cfg_t         csr_cfg  [NREG];
    logic [AW-1:0]    csr_addr [NREG];
    logic [NCH-1:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, rsp_hit;
    logic [NCH-1:0]   fault_clear, fault_valid;
    logic [AW-1:0]    req_addr   [NCH];
    pmp_req_e         req_type   [NCH];
    priv_lvl_e        req_priv   [NCH];
    logic [RW-1:0]    rsp_region [NCH];
    logic [AW-1:0]    fault_addr [NCH];
    pmp_req_e         fault_type [NCH];
    logic [CW-1:0]    fault_cnt  [NCH];

    logic [NCH-1:0]   g1_req_ready, g1_rsp_valid, g1_rsp_err, g1_rsp_hit, g1_fault_valid;
    logic [RW-1:0]    g1_rsp_region [NCH];
    logic [AW-1:0]    g1_fault_addr [NCH];
    pmp_req_e         g1_fault_type [NCH];
    logic [CW-1:0]    g1_fault_cnt  [NCH];

    always #5 clk = ~clk;

    ibex_pmp_pipe #(
        .PMPGranularity(0), .PMPNumChan(NCH), .PMPNumRegions(NREG),
        .PMPAddrWidth(AW), .FaultCntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_pmp_cfg_i(csr_cfg), .csr_pmp_addr_i(csr_addr),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_type_i(req_type), .req_priv_i(req_priv),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_err_o(rsp_err), .rsp_hit_o(rsp_hit), .rsp_region_o(rsp_region),
        .fault_clear_i(fault_clear), .fault_valid_o(fault_valid),
        .fault_addr_o(fault_addr), .fault_type_o(fault_type), .fault_cnt_o(fault_cnt)
    );

    ibex_pmp_pipe #(
        .PMPGranularity(1), .PMPNumChan(NCH), .PMPNumRegions(NREG),
        .PMPAddrWidth(AW), .FaultCntWidth(CW)
    ) dut_g1 (
        .clk_i(clk), .rst_i(rst),
        .csr_pmp_cfg_i(csr_cfg), .csr_pmp_addr_i(csr_addr),
        .req_valid_i(req_valid), .req_ready_o(g1_req_ready),
        .req_addr_i(req_addr), .req_type_i(req_type), .req_priv_i(req_priv),
        .rsp_valid_o(g1_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_err_o(g1_rsp_err), .rsp_hit_o(g1_rsp_hit), .rsp_region_o(g1_rsp_region),
        .fault_clear_i(fault_clear), .fault_valid_o(g1_fault_valid),
        .fault_addr_o(g1_fault_addr), .fault_type_o(g1_fault_type), .fault_cnt_o(g1_fault_cnt)
    );

    typedef struct packed {
        logic          err;
        logic          hit;
        logic [RW-1:0] region;
    } exp_t;

    exp_t sb [$];
    exp_t nx;
    int   total = 0;
    int   bad   = 0;
    int   n_rsp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic pmp_cfg_t mk(input logic l, input pmp_cfg_mode_e m,
                                    input logic x, input logic w, input logic r);
        mk = '{lock: l, mode: m, exec: x, write: w, read: r};
    endfunction

    // One clock: score channel-0 handshakes at the falling edge, then advance.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (rsp_valid[0] && rsp_ready[0]) begin
            n_rsp++;
            chk("sb_avail", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_err", rsp_err[0], e.err);
                chk("rsp_hit", rsp_hit[0], e.hit);
                chk("rsp_region", rsp_region[0], e.region);
            end
        end
        if (req_valid[0] && req_ready[0]) sb.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input pmp_req_e t, input priv_lvl_e p,
                         input logic e_err, input logic e_hit, input logic [RW-1:0] e_reg);
        req_valid[0] = 1'b1;
        req_addr[0]  = a;
        req_type[0]  = t;
        req_priv[0]  = p;
        nx = '{err: e_err, hit: e_hit, region: e_reg};
    endtask

    task automatic req(input logic [AW-1:0] a, input pmp_req_e t, input priv_lvl_e p,
                       input logic e_err, input logic e_hit, input logic [RW-1:0] e_reg);
        drive(a, t, p, e_err, e_hit, e_reg);
        cyc();
        req_valid[0] = 1'b0;
        cyc();
    endtask

    task automatic clr_csr();
        for (int i = 0; i < NREG; i++) begin
            csr_cfg[i]  = mk(1'b0, PMP_MODE_OFF, 1'b0, 1'b0, 1'b0);
            csr_addr[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst         = 1'b1;
        req_valid   = '0;
        rsp_ready   = '1;
        fault_clear = '0;
        for (int c = 0; c < NCH; c++) begin
            req_addr[c] = '0;
            req_type[c] = PMP_ACC_READ;
            req_priv[c] = PRIV_LVL_M;
        end
        clr_csr();
        nx = '0;

        // Reset state, observed while reset is still asserted.
        #12;
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_err", rsp_err[0], 0);
        chk("rst_rsp_hit", rsp_hit[0], 0);
        chk("rst_rsp_region", rsp_region[0], 0);
        chk("rst_fault_valid", fault_valid, 0);
        chk("rst_fault_addr", fault_addr[0], 0);
        chk("rst_fault_type", fault_type[0], PMP_ACC_EXEC);
        chk("rst_fault_cnt", fault_cnt[0], 0);
        chk("rst_req_ready", req_ready, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Priority: NAPOT 0x1000/4KiB read-only beats overlapping TOR RWX.
        csr_cfg[0]  = mk(1'b0, PMP_MODE_NAPOT, 1'b0, 1'b0, 1'b1);
        csr_addr[0] = 34'h17FC;
        csr_cfg[1]  = mk(1'b0, PMP_MODE_TOR, 1'b1, 1'b1, 1'b1);
        csr_addr[1] = 34'h10000;
        req(34'h1800, PMP_ACC_READ,  PRIV_LVL_U, 1'b0, 1'b1, 2'd0);
        req(34'h1800, PMP_ACC_WRITE, PRIV_LVL_U, 1'b1, 1'b1, 2'd0);
        chk("prio_fault_valid", fault_valid[0], 1);
        chk("prio_fault_addr", fault_addr[0], 34'h1800);
        chk("prio_fault_type", fault_type[0], PMP_ACC_WRITE);
        chk("prio_fault_cnt", fault_cnt[0], 1);
        req(34'h8000,  PMP_ACC_WRITE, PRIV_LVL_U, 1'b0, 1'b1, 2'd1);
        req(34'h0100,  PMP_ACC_READ,  PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        req(34'h20000, PMP_ACC_READ,  PRIV_LVL_U, 1'b1, 1'b0, 2'd0);

        // TOR bounds: upper bound strict, empty range never matches.
        clr_csr();
        csr_cfg[0]  = mk(1'b0, PMP_MODE_TOR, 1'b0, 1'b1, 1'b1);
        csr_addr[0] = 34'h2000;
        req(34'h1FFC, PMP_ACC_READ, PRIV_LVL_U, 1'b0, 1'b1, 2'd0);
        req(34'h2000, PMP_ACC_READ, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        csr_cfg[0]  = mk(1'b0, PMP_MODE_OFF, 1'b0, 1'b1, 1'b1);
        csr_cfg[1]  = mk(1'b0, PMP_MODE_TOR, 1'b1, 1'b1, 1'b1);
        csr_addr[1] = 34'h1000;
        req(34'h1800, PMP_ACC_READ, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        req(34'h2000, PMP_ACC_READ, PRIV_LVL_M, 1'b0, 1'b0, 2'd0);

        // Lock in M-mode on an NA4 region; the G=1 instance must treat NA4 as OFF.
        clr_csr();
        csr_cfg[2]  = mk(1'b1, PMP_MODE_NA4, 1'b0, 1'b0, 1'b1);
        csr_addr[2] = 34'h40;
        drive(34'h40, PMP_ACC_WRITE, PRIV_LVL_M, 1'b1, 1'b1, 2'd2);
        cyc();
        chk("g1_rsp_valid", g1_rsp_valid[0], 1);
        chk("g1_na4_hit", g1_rsp_hit[0], 0);
        chk("g1_na4_err", g1_rsp_err[0], 0);
        req_valid[0] = 1'b0;
        cyc();
        req(34'h44, PMP_ACC_WRITE, PRIV_LVL_M, 1'b0, 1'b0, 2'd0);
        req(34'h40, PMP_ACC_READ,  PRIV_LVL_U, 1'b0, 1'b1, 2'd2);
        csr_cfg[2] = mk(1'b0, PMP_MODE_NA4, 1'b0, 1'b0, 1'b1);
        req(34'h40, PMP_ACC_WRITE, PRIV_LVL_M, 1'b0, 1'b1, 2'd2);

        // Handshake: stall with a pending request, change CSRs, then stream.
        clr_csr();
        csr_cfg[0]  = mk(1'b0, PMP_MODE_TOR, 1'b0, 1'b1, 1'b1);
        csr_addr[0] = 34'h2000;
        base = n_rsp;
        rsp_ready[0] = 1'b0;
        drive(34'h100, PMP_ACC_READ, PRIV_LVL_U, 1'b0, 1'b1, 2'd0);
        cyc();
        drive(34'h3000, PMP_ACC_WRITE, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_ready", req_ready[0], 0);
            chk("stall_rsp_valid", rsp_valid[0], 1);
            chk("stall_rsp_err", rsp_err[0], 0);
            chk("stall_rsp_hit", rsp_hit[0], 1);
            if (i == 1) csr_cfg[0] = mk(1'b0, PMP_MODE_OFF, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        rsp_ready[0] = 1'b1;
        cyc();
        drive(34'h4000, PMP_ACC_READ, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        chk("stream_rsp_valid_2", rsp_valid[0], 1);
        cyc();
        req_valid[0] = 1'b0;
        chk("stream_rsp_valid_3", rsp_valid[0], 1);
        cyc();
        chk("stream_drained", rsp_valid[0], 0);
        chk("stream_rsp_count", n_rsp - base, 3);

        // Fault capture, clear-with-fault, clear alone, and counter saturation.
        do_reset();
        clr_csr();
        req(34'h100, PMP_ACC_READ,  PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        req(34'h200, PMP_ACC_WRITE, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        chk("cap_valid", fault_valid[0], 1);
        chk("cap_addr", fault_addr[0], 34'h100);
        chk("cap_type", fault_type[0], PMP_ACC_READ);
        chk("cap_cnt", fault_cnt[0], 2);
        chk("ch1_cnt", fault_cnt[1], 0);
        chk("ch1_valid", fault_valid[1], 0);
        drive(34'h300, PMP_ACC_EXEC, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        cyc();
        req_valid[0]   = 1'b0;
        fault_clear[0] = 1'b1;
        cyc();
        fault_clear[0] = 1'b0;
        chk("clrfault_valid", fault_valid[0], 1);
        chk("clrfault_addr", fault_addr[0], 34'h300);
        chk("clrfault_type", fault_type[0], PMP_ACC_EXEC);
        chk("clrfault_cnt", fault_cnt[0], 3);
        fault_clear[0] = 1'b1;
        cyc();
        fault_clear[0] = 1'b0;
        chk("clr_valid", fault_valid[0], 0);
        chk("clr_cnt_kept", fault_cnt[0], 3);
        req(34'h500, PMP_ACC_READ,  PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        req(34'h600, PMP_ACC_WRITE, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        chk("sat_addr", fault_addr[0], 34'h500);
        chk("sat_type", fault_type[0], PMP_ACC_READ);
        chk("sat_cnt", fault_cnt[0], 3);

        // Asynchronous reset with a held faulting response in flight.
        rsp_ready[0] = 1'b0;
        drive(34'h700, PMP_ACC_READ, PRIV_LVL_U, 1'b1, 1'b0, 2'd0);
        cyc();
        req_valid[0] = 1'b0;
        chk("pre_rst_valid", rsp_valid[0], 1);
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", rsp_valid[0], 0);
        chk("arst_rsp_err", rsp_err[0], 0);
        chk("arst_fault_valid", fault_valid[0], 0);
        chk("arst_fault_addr", fault_addr[0], 0);
        chk("arst_fault_type", fault_type[0], PMP_ACC_EXEC);
        chk("arst_fault_cnt", fault_cnt[0], 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        chk("lost_rsp_valid", rsp_valid[0], 0);
        chk("post_rst_cnt", fault_cnt[0], 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
